// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder sequencer: FSM state encoding,
// default operand width and small helper functions used by the datapath.
package serial_add_pkg;

    // IDLE waits for start, SHIFT processes one bit per clock, DONE pulses done.
    // The unused encoding 2'd3 is steered back to IDLE by the next-state logic.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // Width of the bit counter that walks through WIDTH bit positions.
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

    // Carry generate of a one-bit full adder.
    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/serial_full_adder.sv
// One-bit full adder with a registered carry. The sum bit is combinational
// from the operand bits and the current carry; the carry advances only when
// enabled and is preloaded with the carry-in at the start of an addition.
module serial_full_adder
    import serial_add_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic cin_load,
    input  logic x,
    input  logic y,
    input  logic en,
    output logic s,
    output logic carry
);

    logic r_carry;

    // Carry register: cleared on reset, preloaded on load, advanced per shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_carry <= 1'b0;
        end else if (load) begin
            r_carry <= cin_load;
        end else if (en) begin
            r_carry <= maj3(x, y, r_carry);
        end
    end

    assign s     = x ^ y ^ r_carry;
    assign carry = r_carry;

endmodule

// File: rtl/serial_add_ctrl.sv
// Sequencer around a bit-serial adder. Captures two operands and a carry-in on
// an accepted start, shifts them LSB-first through a one-bit full adder, and
// assembles the sum MSB-in so bit 0 lands in place after WIDTH shifts.
// Completion is flagged by a single-cycle done pulse; busy covers SHIFT and DONE.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int                CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic             w_shift;
    logic             w_last;
    logic             w_s;
    logic             w_carry;

    // Start is only honoured in IDLE; in SHIFT/DONE it is ignored entirely.
    assign w_accept = (r_state == IDLE) && start;
    assign w_shift  = (r_state == SHIFT);
    assign w_last   = w_shift && (r_cnt == CNT_LAST);

    serial_full_adder u_fa (
        .clk      (clk),
        .reset    (reset),
        .load     (w_accept),
        .cin_load (cin),
        .x        (r_op_a[0]),
        .y        (r_op_b[0]),
        .en       (w_shift),
        .s        (w_s),
        .carry    (w_carry)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; the unused encoding falls back to IDLE.
    always_comb begin
        w_state_nxt = IDLE;
        case (r_state)
            IDLE:    w_state_nxt = start ? SHIFT : IDLE;
            SHIFT:   w_state_nxt = (r_cnt == CNT_LAST) ? DONE : SHIFT;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from the state register only (no input-to-output path).
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            SHIFT: busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Operand shifters, sum assembly, bit counter and carry-out capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op_a <= '0;
            r_op_b <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_op_a <= a;
            r_op_b <= b;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_cnt  <= '0;
        end else if (w_shift) begin
            r_op_a <= r_op_a >> 1;
            r_op_b <= r_op_b >> 1;
            r_sum  <= {w_s, r_sum[WIDTH-1:1]};
            r_cnt  <= r_cnt + CNT_W'(1);
            // Carry-out is the carry produced by the final bit position.
            if (w_last) begin
                r_cout <= maj3(r_op_a[0], r_op_b[0], w_carry);
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=4 and WIDTH=8. Inputs change on
// the falling edge, outputs are sampled on the falling edge.
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;

    logic       start4;
    logic [3:0] a4, b4;
    logic       cin4;
    logic [3:0] sum4;
    logic       cout4, busy4, done4;

    logic       start8;
    logic [7:0] a8, b8;
    logic       cin8;
    logic [7:0] sum8;
    logic       cout8, busy8, done8;

    int checks = 0;
    int errors = 0;

    int       n;
    int       nd;
    bit       found;
    logic [4:0] ref5;

    serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .sum   (sum4),
        .cout  (cout4),
        .busy  (busy4),
        .done  (done4)
    );

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .sum   (sum8),
        .cout  (cout8),
        .busy  (busy8),
        .done  (done8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=4 addition. Step i is the falling edge after start edge E0 + i.
    // With keep set, start stays high and a becomes 1111 while the op is busy.
    task automatic run4(input logic [3:0] ta, input logic [3:0] tb_, input logic tc,
                        input logic [3:0] es, input logic ec, input bit keep,
                        input string tag);
        int nb;
        int ndn;
        int dpos;
        nb   = 0;
        ndn  = 0;
        dpos = -1;
        @(negedge clk);
        a4 = ta; b4 = tb_; cin4 = tc; start4 = 1'b1;
        @(negedge clk);
        if (keep) a4 = 4'hF;
        else      start4 = 1'b0;
        for (int i = 0; i <= 5; i++) begin
            if (busy4) nb++;
            if (done4) begin
                ndn++;
                dpos = i;
            end
            if (i == 4) begin
                chk({tag, " sum"},  32'(sum4),  32'(es));
                chk({tag, " cout"}, 32'(cout4), 32'(ec));
            end
            if (i == 5) begin
                chk({tag, " sum idle hold"},  32'(sum4),  32'(es));
                chk({tag, " cout idle hold"}, 32'(cout4), 32'(ec));
            end
            if (i < 5) @(negedge clk);
        end
        chk({tag, " busy cycles"}, 32'(nb),   32'd5);
        chk({tag, " done pulses"}, 32'(ndn),  32'd1);
        chk({tag, " done cycle"},  32'(dpos), 32'd4);
    endtask

    initial begin
        reset  = 1'b1;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst sum4",  32'(sum4),  32'd0);
        chk("rst cout4", 32'(cout4), 32'd0);
        chk("rst busy4", 32'(busy4), 32'd0);
        chk("rst done4", 32'(done4), 32'd0);
        chk("rst sum8",  32'(sum8),  32'd0);
        chk("rst busy8", 32'(busy8), 32'd0);
        reset = 1'b0;

        // Basic addition and carry boundaries.
        run4(4'b0011, 4'b0101, 1'b0, 4'b1000, 1'b0, 1'b0, "3+5");
        repeat (3) @(negedge clk);
        chk("3+5 sum held",  32'(sum4),  32'h8);
        chk("3+5 cout held", 32'(cout4), 32'd0);
        run4(4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, "F+1");
        run4(4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0, "F+F+1");

        // Start held high while busy: ignored until IDLE, then accepted at once.
        run4(4'b0011, 4'b0101, 1'b0, 4'b1000, 1'b0, 1'b1, "3+5 held start");
        @(negedge clk);
        chk("restart accepted busy", 32'(busy4), 32'd1);
        chk("restart sum cleared",   32'(sum4),  32'd0);
        start4 = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (done4) found = 1'b1;
        end
        chk("restart done seen", 32'(found), 32'd1);
        chk("restart sum F+5",   32'(sum4),  32'h4);
        chk("restart cout F+5",  32'(cout4), 32'd1);

        // Reset during the second SHIFT cycle aborts the operation.
        @(negedge clk);
        a4 = 4'b0011; b4 = 4'b0101; cin4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort sum",  32'(sum4),  32'd0);
        chk("abort cout", 32'(cout4), 32'd0);
        chk("abort busy", 32'(busy4), 32'd0);
        chk("abort done", 32'(done4), 32'd0);
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done4) nd++;
        end
        chk("abort no done", 32'(nd), 32'd0);
        run4(4'b0001, 4'b0001, 1'b0, 4'b0010, 1'b0, 1'b0, "1+1 after abort");

        // WIDTH=8: 200 + 100 = 300 -> sum 0x2C, carry out.
        @(negedge clk);
        a8 = 8'd200; b8 = 8'd100; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n = 0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (done8) found = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        chk("w8 done seen",  32'(found), 32'd1);
        chk("w8 done cycle", 32'(n),     32'd8);
        chk("w8 sum",        32'(sum8),  32'h2C);
        chk("w8 cout",       32'(cout8), 32'd1);

        // Exhaustive WIDTH=4 sweep against a + b + cin.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    ref5 = 5'(ia) + 5'(ib) + 5'(ic);
                    run4(4'(ia), 4'(ib), 1'(ic), ref5[3:0], ref5[4], 1'b0, "sweep");
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
